// File: rtl/multi_pll_reset_monitor.sv
// Supervises NUM_PLLS PLLs: drives resets, debounces lock, flags timeout/loss, exposes an Avalon-MM CSR slave.
// Build macro PLL_MON_AUTO_RETRY_EN enables automatic re-reset of timed-out channels (up to MAX_RETRIES).
module multi_pll_reset_monitor #(
  parameter int NUM_PLLS            = 4,
  parameter int LOCK_STABLE_CYCLES  = 16,
  parameter int LOCK_TIMEOUT_CYCLES = 256,
  parameter int RESET_PULSE_CYCLES  = 8,
  parameter int MAX_RETRIES         = 3
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [NUM_PLLS-1:0] pll_locked,
  input  logic [NUM_PLLS-1:0] pll_reset_request,
  output logic [NUM_PLLS-1:0] pll_reset,
  output logic [NUM_PLLS-1:0] lock_success,
  output logic [NUM_PLLS-1:0] lock_failure,
  input  logic [4:0]          s0_address,
  input  logic                s0_read,
  input  logic                s0_write,
  input  logic [31:0]         s0_writedata,
  output logic [31:0]         s0_readdata
);

`ifdef PLL_MON_AUTO_RETRY_EN
  localparam bit AUTO_RETRY = 1'b1;
`else
  localparam bit AUTO_RETRY = 1'b0;
`endif

  typedef enum logic [2:0] {ST_RESET, ST_WAIT_LOCK, ST_LOCKED, ST_FAILED, ST_LOST} state_t;

  logic [31:0] csr_word [NUM_PLLS];
  logic [31:0] summary_word;
  logic [31:0] read_next;
  logic        unused_wdata;

  assign unused_wdata = &{1'b0, s0_writedata[31:2]};

  for (genvar gi = 0; gi < NUM_PLLS; gi++) begin : g_ch
    state_t      state_reg, state_next;
    logic [2:0]  sync_reg;
    logic [7:0]  pulse_reg, pulse_next;
    logic [15:0] cycles_reg, cycles_next;
    logic [7:0]  stutter_reg, stutter_next;
    logic [7:0]  stable_reg, stable_next;
    logic        lost_reg, lost_next;
    logic [2:0]  retry_reg, retry_next;
    logic        locked, locked_prev, sel, req;

    // sync_reg[1] is the synchronised lock; sync_reg[2] is its previous value for fall detection
    assign locked      = sync_reg[1];
    assign locked_prev = sync_reg[2];
    assign sel         = s0_write && (s0_address == 5'(gi));
    assign req         = pll_reset_request[gi] || (sel && s0_writedata[0]);

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        state_reg   <= ST_RESET;
        sync_reg    <= '0;
        pulse_reg   <= '0;
        cycles_reg  <= '0;
        stutter_reg <= '0;
        stable_reg  <= '0;
        lost_reg    <= 1'b0;
        retry_reg   <= '0;
      end else begin
        state_reg   <= state_next;
        sync_reg    <= {sync_reg[1:0], pll_locked[gi]};
        pulse_reg   <= pulse_next;
        cycles_reg  <= cycles_next;
        stutter_reg <= stutter_next;
        stable_reg  <= stable_next;
        lost_reg    <= lost_next;
        retry_reg   <= retry_next;
      end
    end

    always_comb begin
      state_next   = state_reg;
      pulse_next   = pulse_reg;
      cycles_next  = cycles_reg;
      stutter_next = stutter_reg;
      stable_next  = stable_reg;
      lost_next    = lost_reg && !(sel && s0_writedata[1]);
      retry_next   = retry_reg;
      if (req) begin
        state_next = ST_RESET;
        retry_next = '0;
      end else begin
        case (state_reg)
          ST_RESET: begin
            if (pulse_reg >= 8'(RESET_PULSE_CYCLES)) state_next = ST_WAIT_LOCK;
            else pulse_next = pulse_reg + 8'd1;
          end
          ST_WAIT_LOCK: begin
            cycles_next = (cycles_reg == 16'hFFFF) ? cycles_reg : cycles_reg + 16'd1;
            stable_next = locked ? stable_reg + 8'd1 : 8'd0;
            if (locked_prev && !locked && stutter_reg != 8'hFF) stutter_next = stutter_reg + 8'd1;
            // success is tested first so it wins a same-cycle timeout
            if (stable_next == 8'(LOCK_STABLE_CYCLES)) begin
              state_next = ST_LOCKED;
            end else if (cycles_next >= 16'(LOCK_TIMEOUT_CYCLES)) begin
              if (AUTO_RETRY && retry_reg < 3'(MAX_RETRIES)) begin
                retry_next = retry_reg + 3'd1;
                state_next = ST_RESET;
              end else begin
                state_next = ST_FAILED;
              end
            end
          end
          ST_LOCKED: begin
            if (!locked) begin
              state_next = ST_LOST;
              lost_next  = 1'b1;
            end
          end
          default: ;
        endcase
      end
      // every (re)entry into RESET starts a fresh attempt; lost and retry count survive it
      if (state_next == ST_RESET && (req || state_reg != ST_RESET)) begin
        pulse_next   = '0;
        cycles_next  = '0;
        stutter_next = '0;
        stable_next  = '0;
      end
    end

    assign pll_reset[gi]    = (state_reg == ST_RESET);
    assign lock_success[gi] = (state_reg == ST_LOCKED);
    assign lock_failure[gi] = (state_reg == ST_FAILED) || (state_reg == ST_LOST);
    assign csr_word[gi]     = {2'b00, retry_reg, lost_reg, lock_failure[gi], lock_success[gi],
                               stutter_reg, cycles_reg};
  end

  always_comb begin
    summary_word                   = '0;
    summary_word[NUM_PLLS-1:0]     = lock_success;
    summary_word[16 +: NUM_PLLS]   = lock_failure;
    read_next                      = '0;
    if (s0_address == 5'(NUM_PLLS)) read_next = summary_word;
    for (int i = 0; i < NUM_PLLS; i++) begin
      if (s0_address == 5'(i)) read_next = csr_word[i];
    end
  end

  // registered read captures pre-write state, so a same-cycle write is not visible yet
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) s0_readdata <= '0;
    else if (s0_read) s0_readdata <= read_next;
  end

endmodule

// File: tb/tb_multi_pll_reset_monitor.sv
// Self-checking bench for multi_pll_reset_monitor; CSR reads are checked through an expected-value queue.
module tb_multi_pll_reset_monitor;
  localparam int NUM = 4;
`ifdef PLL_MON_AUTO_RETRY_EN
  localparam int EXP_RETRIES = 3;
`else
  localparam int EXP_RETRIES = 0;
`endif

  logic           clk = 1'b0;
  logic           reset_n = 1'b0;
  logic [NUM-1:0] pll_locked = '0;
  logic [NUM-1:0] pll_reset_request = '0;
  logic [NUM-1:0] pll_reset, lock_success, lock_failure;
  logic [4:0]     s0_address = '0;
  logic           s0_read = 1'b0;
  logic           s0_write = 1'b0;
  logic [31:0]    s0_writedata = '0;
  logic [31:0]    s0_readdata;

  int          n_checks = 0;
  int          n_fail = 0;
  logic [31:0] exp_q[$];
  int          wait_cnt [NUM];

  multi_pll_reset_monitor dut (
    .clk(clk), .reset_n(reset_n), .pll_locked(pll_locked), .pll_reset_request(pll_reset_request),
    .pll_reset(pll_reset), .lock_success(lock_success), .lock_failure(lock_failure),
    .s0_address(s0_address), .s0_read(s0_read), .s0_write(s0_write),
    .s0_writedata(s0_writedata), .s0_readdata(s0_readdata)
  );

  always #5 clk = ~clk;

  // Independent count of cycles each channel spends waiting for lock (reset low, no verdict)
  always @(negedge clk) begin
    for (int i = 0; i < NUM; i++) begin
      if (!reset_n || pll_reset[i]) wait_cnt[i] <= 0;
      else if (!lock_success[i] && !lock_failure[i]) wait_cnt[i] <= wait_cnt[i] + 1;
    end
  end

  task automatic csr_read(input logic [4:0] addr, output logic [31:0] data);
    s0_address = addr;
    s0_read    = 1'b1;
    @(negedge clk);
    s0_read = 1'b0;
    data    = s0_readdata;
  endtask

  task automatic csr_write(input logic [4:0] addr, input logic [31:0] data);
    s0_address   = addr;
    s0_writedata = data;
    s0_write     = 1'b1;
    @(negedge clk);
    s0_write = 1'b0;
  endtask

  task automatic test_reset;
    logic [31:0] got, exp;
    pll_reset_request = 4'b1110;
    repeat (3) @(negedge clk);
    n_checks++;
    if (pll_reset !== 4'hF) begin n_fail++; $display("FAIL reset_pll_reset: got %h expected f", pll_reset); end
    n_checks++;
    if (lock_success !== 4'h0) begin n_fail++; $display("FAIL reset_success: got %h expected 0", lock_success); end
    n_checks++;
    if (lock_failure !== 4'h0) begin n_fail++; $display("FAIL reset_failure: got %h expected 0", lock_failure); end
    n_checks++;
    if (s0_readdata !== 32'h0) begin n_fail++; $display("FAIL reset_readdata: got %h expected 0", s0_readdata); end
    reset_n = 1'b1;
    @(negedge clk);
    for (int a = 0; a < 2; a++) begin
      exp_q.push_back(32'h0);
      csr_read(5'(a), got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL reset_csr%0d: read %h expected %h", a, got, exp); end
    end
    $display("test_reset done");
  endtask

  task automatic test_stutter_lock;
    logic [31:0] got, exp;
    int cyc;
    repeat (128) @(negedge clk);
    for (int t = 0; t < 4; t++) begin
      pll_locked[0] = 1'b1;
      repeat (5) @(negedge clk);
      pll_locked[0] = 1'b0;
      @(negedge clk);
    end
    pll_locked[0] = 1'b1;
    cyc = 0;
    while (!lock_success[0] && cyc < 200) begin @(negedge clk); cyc++; end
    n_checks++;
    if (lock_success[0] !== 1'b1) begin n_fail++; $display("FAIL stutter_success: got %b expected 1", lock_success[0]); end
    exp_q.push_back({2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 8'd4, 16'(wait_cnt[0])});
    csr_read(5'd0, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL stutter_csr0: read %h expected %h", got, exp); end
    $display("test_stutter_lock: csr0=%h waited %0d cycles", got, wait_cnt[0]);
  endtask

  task automatic test_timeout_retry;
    logic [31:0] got, exp;
    int cyc, pulses;
    logic prev;
    pll_reset_request[1] = 1'b0;
    pulses = 0;
    prev = pll_reset[1];
    for (cyc = 0; cyc < 3000 && !lock_failure[1]; cyc++) begin
      if (cyc == 20) pll_reset_request[3:2] = 2'b00;
      @(negedge clk);
      if (pll_reset[1] && !prev) pulses++;
      prev = pll_reset[1];
    end
    n_checks++;
    if (lock_failure[1] !== 1'b1) begin n_fail++; $display("FAIL timeout_failure: got %b expected 1", lock_failure[1]); end
    n_checks++;
    if (wait_cnt[1] != 256) begin n_fail++; $display("FAIL timeout_cycles: got %0d expected 256", wait_cnt[1]); end
    n_checks++;
    if (pulses != EXP_RETRIES) begin n_fail++; $display("FAIL retry_pulses: got %0d expected %0d", pulses, EXP_RETRIES); end
    exp_q.push_back(32'h0200_0100 | (32'(EXP_RETRIES) << 27));
    csr_read(5'd1, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL timeout_csr1: read %h expected %h", got, exp); end
    $display("test_timeout_retry: csr1=%h retries=%0d", got, pulses);
  endtask

  task automatic test_summary;
    logic [31:0] got, exp;
    exp_q.push_back(32'h0002_0001);
    csr_read(5'd4, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL summary_csr4: read %h expected %h", got, exp); end
    s0_address = 5'd0;
    @(negedge clk);
    n_checks++;
    if (s0_readdata !== exp) begin n_fail++; $display("FAIL readdata_hold: got %h expected %h", s0_readdata, exp); end
    for (int k = 0; k < 2; k++) begin
      exp_q.push_back(32'h0);
      csr_read((k == 0) ? 5'd9 : 5'd31, got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL out_of_range_read%0d: read %h expected %h", k, got, exp); end
    end
    $display("test_summary done");
  endtask

  task automatic test_loss;
    logic [31:0] got, exp;
    logic [15:0] lc;
    int cyc;
    pll_locked[2] = 1'b1;
    pll_reset_request[2] = 1'b1;
    @(negedge clk);
    pll_reset_request[2] = 1'b0;
    cyc = 0;
    while (!lock_success[2] && cyc < 200) begin @(negedge clk); cyc++; end
    n_checks++;
    if (lock_success[2] !== 1'b1) begin n_fail++; $display("FAIL loss_lock: got %b expected 1", lock_success[2]); end
    lc = 16'(wait_cnt[2]);
    exp_q.push_back({2'b00, 3'b000, 1'b0, 1'b0, 1'b1, 8'd0, lc});
    csr_read(5'd2, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL loss_csr_locked: read %h expected %h", got, exp); end
    pll_locked[2] = 1'b0;
    @(negedge clk);
    pll_locked[2] = 1'b1;
    cyc = 1;
    while (cyc < 3 && !(lock_failure[2] && !lock_success[2])) begin @(negedge clk); cyc++; end
    n_checks++;
    if ({lock_failure[2], lock_success[2]} !== 2'b10) begin
      n_fail++; $display("FAIL loss_detect: fail/succ %b%b expected 10", lock_failure[2], lock_success[2]);
    end
    exp_q.push_back({2'b00, 3'b000, 1'b1, 1'b1, 1'b0, 8'd0, lc});
    csr_read(5'd2, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL loss_csr_lost: read %h expected %h", got, exp); end
    // same-cycle read and clear-lost write: the read reports the pre-write word
    exp_q.push_back({2'b00, 3'b000, 1'b1, 1'b1, 1'b0, 8'd0, lc});
    s0_address = 5'd2; s0_writedata = 32'h2; s0_write = 1'b1; s0_read = 1'b1;
    @(negedge clk);
    s0_write = 1'b0; s0_read = 1'b0;
    got = s0_readdata;
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL rw_same_cycle: read %h expected %h", got, exp); end
    exp_q.push_back({2'b00, 3'b000, 1'b0, 1'b1, 1'b0, 8'd0, lc});
    csr_read(5'd2, got);
    exp = exp_q.pop_front();
    n_checks++;
    if (got !== exp) begin n_fail++; $display("FAIL lost_clear: read %h expected %h", got, exp); end
    n_checks++;
    if (lock_failure[2] !== 1'b1) begin n_fail++; $display("FAIL lost_failure_held: got %b expected 1", lock_failure[2]); end
    $display("test_loss: csr2=%h", got);
  endtask

  task automatic test_reset_abort;
    logic [31:0] got, exp;
    int cyc, hi;
    bit fail_seen;
    pll_locked[3] = 1'b0;
    pll_reset_request[3] = 1'b1;
    @(negedge clk);
    pll_reset_request[3] = 1'b0;
    for (int pass = 0; pass < 2; pass++) begin
      cyc = 0;
      while (pll_reset[3] && cyc < 100) begin @(negedge clk); cyc++; end
      repeat (10) @(negedge clk);
      if (pass == 0) begin
        pll_reset_request[3] = 1'b1;
        @(negedge clk);
        pll_reset_request[3] = 1'b0;
      end else begin
        csr_write(5'd3, 32'h1);
      end
      hi = 0;
      fail_seen = 1'b0;
      while (pll_reset[3] && hi < 100) begin
        hi++;
        if (lock_failure[3]) fail_seen = 1'b1;
        @(negedge clk);
      end
      n_checks++;
      if (hi < 8) begin n_fail++; $display("FAIL abort%0d_pulse_len: got %0d expected >= 8", pass, hi); end
      n_checks++;
      if (fail_seen || lock_failure[3] !== 1'b0) begin
        n_fail++; $display("FAIL abort%0d_no_failure: got %b expected 0", pass, fail_seen | lock_failure[3]);
      end
      exp_q.push_back(32'h0);
      csr_read(5'd3, got);
      exp = exp_q.pop_front();
      n_checks++;
      if (got !== exp) begin n_fail++; $display("FAIL abort%0d_csr3: read %h expected %h", pass, got, exp); end
      $display("test_reset_abort pass %0d: reset held %0d cycles, csr3=%h", pass, hi, got);
    end
  endtask

  initial begin
    test_reset();
    test_stutter_lock();
    test_timeout_retry();
    test_summary();
    test_loss();
    test_reset_abort();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/multi_pll_reset_monitor.md
Name: multi_pll_reset_monitor

Overview:
- Parametrised successor to the single-PLL reset monitor. Supervises NUM_PLLS PLLs from one reference clock.
- Per channel it:
  - drives the PLL reset;
  - debounces pll_locked and classifies the result as lock success or lock failure (timeout);
  - counts lock stutters;
  - detects loss of lock after success.
- Status and control are exposed on an Avalon-MM slave (s0) in the same clock domain.
- Sits between the PLL instances and the system reset sequencers.

Parameters:
- NUM_PLLS, 4, number of monitored channels (1..16).
- LOCK_STABLE_CYCLES, 16, consecutive synchronised-locked cycles needed to declare success (2..255).
- LOCK_TIMEOUT_CYCLES, 256, maximum WAIT_LOCK cycles before failure (LOCK_STABLE_CYCLES+1..65535).
- RESET_PULSE_CYCLES, 8, minimum pll_reset assertion length (1..255).
- MAX_RETRIES, 3, auto-retry limit; used only with the optional feature (1..7).

Ports:
- clk  in  1  reference clock; all logic is in this domain.
- reset_n  in  1  asynchronous active-low reset.
- pll_locked  in  NUM_PLLS  raw PLL lock indications; asynchronous, synchronised internally.
- pll_reset_request  in  NUM_PLLS  level reset request per channel.
- pll_reset  out  NUM_PLLS  reset to each PLL, active-high.
- lock_success  out  NUM_PLLS  channel in LOCKED.
- lock_failure  out  NUM_PLLS  channel in FAILED or LOST.
- s0_address  in  5  word address.
- s0_read  in  1  read strobe.
- s0_write  in  1  write strobe.
- s0_writedata  in  32  write data.
- s0_readdata  out  32  read data.

Behaviour:
- Reset (reset_n low, async):
  - pll_reset = all ones.
  - lock_success, lock_failure, s0_readdata = 0.
  - All counters and flags = 0; all channels in RESET.
- Sync: pll_locked goes through a 2-flop synchroniser per bit. "locked" below means the synchronised value.
- Per-channel FSM states: RESET, WAIT_LOCK, LOCKED, FAILED, LOST.
- RESET:
  - pll_reset[i] = 1; pulse counter counts.
  - Leave to WAIT_LOCK when pulse count ≥ RESET_PULSE_CYCLES and request is low.
  - On entry, clear lock_cycles, stutter, stable count, success and failure. lost is sticky and is not cleared.
- WAIT_LOCK:
  - lock_cycles increments every cycle, saturating at 0xFFFF.
  - stable count increments while locked=1 and clears when locked=0.
  - A 1→0 transition of locked increments stutter, saturating at 255.
  - stable count reaching LOCK_STABLE_CYCLES → LOCKED.
  - lock_cycles reaching LOCK_TIMEOUT_CYCLES → FAILED.
  - If both happen in the same cycle, success wins.
- LOCKED:
  - lock_success[i] = 1; lock_cycles is frozen.
  - locked=0 → LOST; set the sticky lost flag.
- FAILED and LOST:
  - lock_failure[i] = 1; lock_success[i] = 0.
  - Held until a reset request.
- Channel reset requests:
  - pll_reset_request[i]=1 or a soft reset write, in any state → RESET next cycle, restarting the pulse count.
  - A request arriving mid-WAIT_LOCK aborts the attempt with no failure flagged.
- CSR map, address i < NUM_PLLS, read:
  - [15:0] lock_cycles
  - [23:16] stutter
  - [24] success
  - [25] failure
  - [26] lost
  - [29:27] retry count
  - [31:30] = 0
- CSR write, address i:
  - bit0 = 1: soft reset pulse for channel i.
  - bit1 = 1: clear the lost flag.
  - Other bits are ignored.
- Address NUM_PLLS, read: [NUM_PLLS-1:0] = lock_success, [16+NUM_PLLS-1:16] = lock_failure. Writes to this address are ignored.
- Other addresses: reads return 0; writes are ignored.
- Read latency is fixed at 1 cycle; no waitrequest. s0_readdata holds its last value when s0_read is low.
- Simultaneous read and write to the same address: the read returns pre-write contents.

Optional Feature:
- Macro: PLL_MON_AUTO_RETRY_EN.
- Defined:
  - Entering FAILED with retry count < MAX_RETRIES increments the retry count and goes to RESET automatically.
  - Once the count reaches MAX_RETRIES, the channel stays in FAILED.
  - The retry count clears only on an external or soft reset request.
  - LOST does not auto-retry.
- Not defined: FAILED is terminal until a request arrives, and retry count bits read 0.

Test Plan:
1. Stutter then lock on ch0, defaults:
   - Stimulus: after reset release, wait 128 clk; then locked 1/0 toggles 4 times (1 clk low, 5 high); then hold high.
   - Response: lock_success[0]=1; read addr 0 → stutter=4, success=1, failure=0; lock_cycles matches the bench's count of WAIT_LOCK cycles.
2. Lock never asserts on ch1:
   - Stimulus: hold pll_locked[1]=0.
   - Response: lock_failure[1]=1 after exactly 256 WAIT_LOCK cycles; read addr 1 = 0x02000100.
3. Success then loss on ch2:
   - Stimulus: lock, then drop pll_locked[2] for 1 clk.
   - Response: within 3 clk, lock_failure[2]=1 and lock_success[2]=0; read bit26=1.
   - Then write 0x2 to addr 2: bit26 clears and failure stays 1.
4. Reset mid-operation:
   - Stimulus: pulse pll_reset_request[3] during WAIT_LOCK.
   - Response: pll_reset[3] high ≥ 8 clk; counters clear; no failure flagged.
   - Soft write 0x1 to addr 3 gives identical behaviour.
5. Summary and out-of-range reads:
   - Stimulus: ch0 success, ch1 failure, ch2/ch3 still waiting.
   - Response: read addr 4 = 0x00020001; read addr 9 = 0x00000000.
6. With PLL_MON_AUTO_RETRY_EN, ch1 locked held 0:
   - Response: three automatic reset pulses, then FAILED persists; read retry count = 3 (bits[29:27] = 3'b011).
